// File: rtl/lsu.sv
// lsu: load/store unit issuing one naturally aligned req/ack bus access per request,
// returning extended load data or a fault for illegal/misaligned accesses.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   address,
    input  logic [XLEN-1:0]   store_data,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nx;
    logic st_q, fault_q, illegal, misaligned, accept, sx;
    logic [2:0] f3_q;
    logic [XLEN-1:0] addr_q, sd_q, rdata_q, lane;
    logic [OW-1:0] off;
    logic [7:0] smask;
    logic [63:0] lane64, ext64;
    always_comb begin
        accept = state == IDLE && req_valid;
        illegal = funct3 == 3'b111 || (is_store && funct3[2]) ||
                  (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110));
        misaligned = funct3[1:0] == 2'b01 ? address[0] :
                     funct3[1:0] == 2'b10 ? |address[1:0] :
                     funct3[1:0] == 2'b11 ? |address[2:0] : 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (req_valid ? ((illegal || misaligned) ? RESP : BUS) : IDLE) :
                   state == BUS  ? (mem_ack ? RESP : BUS) : IDLE;
    end
    // Load data is extended at capture so RESP just presents the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= 1'b0;
            fault_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            sd_q    <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            st_q    <= is_store;
            fault_q <= illegal || misaligned;
            f3_q    <= funct3;
            addr_q  <= address;
            sd_q    <= store_data;
            rdata_q <= '0;
        end else if (state == BUS && mem_ack && !st_q) begin
            rdata_q <= ext64[XLEN-1:0];
        end
    end
    always_comb begin
        off    = addr_q[OW-1:0];
        smask  = f3_q[1:0] == 2'b00 ? 8'h01 : f3_q[1:0] == 2'b01 ? 8'h03 :
                 f3_q[1:0] == 2'b10 ? 8'h0F : 8'hFF;
        lane   = mem_rdata >> {off, 3'b000};
        lane64 = 64'(lane);
        sx     = ~f3_q[2];
        ext64  = f3_q[1:0] == 2'b00 ? {{56{sx & lane64[7]}}, lane64[7:0]} :
                 f3_q[1:0] == 2'b01 ? {{48{sx & lane64[15]}}, lane64[15:0]} :
                 f3_q[1:0] == 2'b10 ? {{32{sx & lane64[31]}}, lane64[31:0]} : lane64;
        req_ready  = state == IDLE;
        mem_req    = state == BUS;
        mem_we     = mem_req && st_q;
        mem_addr   = mem_req ? addr_q & ~XLEN'(NB - 1) : '0;
        mem_wdata  = mem_req ? sd_q << {off, 3'b000} : '0;
        mem_wstrb  = mem_we ? NB'(smask) << off : '0;
        resp_valid = state == RESP;
        resp_data  = resp_valid ? rdata_q : '0;
        fault      = resp_valid && fault_q;
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu at XLEN=32 and XLEN=64.
module tb_lsu;
    logic clk = 1'b0, rst = 1'b1;
    logic rv, st, rr, rsv, flt, mrq, mwe, ack;
    logic [2:0] f3;
    logic [31:0] ad, sd, rsd, maddr, mwd, rd;
    logic [3:0] mws;
    logic rv6, st6, rr6, rsv6, flt6, mrq6, mwe6, ack6;
    logic [2:0] f36;
    logic [63:0] ad6, sd6, rsd6, maddr6, mwd6, rd6;
    logic [7:0] mws6;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rr), .is_store(st), .funct3(f3),
        .address(ad), .store_data(sd), .resp_valid(rsv), .resp_data(rsd), .fault(flt),
        .mem_req(mrq), .mem_we(mwe), .mem_addr(maddr), .mem_wdata(mwd), .mem_wstrb(mws),
        .mem_ack(ack), .mem_rdata(rd)
    );
    lsu #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .req_valid(rv6), .req_ready(rr6), .is_store(st6), .funct3(f36),
        .address(ad6), .store_data(sd6), .resp_valid(rsv6), .resp_data(rsd6), .fault(flt6),
        .mem_req(mrq6), .mem_we(mwe6), .mem_addr(maddr6), .mem_wdata(mwd6), .mem_wstrb(mws6),
        .mem_ack(ack6), .mem_rdata(rd6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req32(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        rv = 1'b1; st = s; f3 = f; ad = a; sd = d;
        tick();
        rv = 1'b0;
    endtask

    task automatic req64(input logic s, input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
        rv6 = 1'b1; st6 = s; f36 = f; ad6 = a; sd6 = d;
        tick();
        rv6 = 1'b0;
    endtask

    initial begin
        rv = 0; st = 0; f3 = 0; ad = 0; sd = 0; ack = 0; rd = 0;
        rv6 = 0; st6 = 0; f36 = 0; ad6 = 0; sd6 = 0; ack6 = 0; rd6 = 0;
        tick();
        tick();
        chk("rst_ready", {63'd0, rr}, 64'd1);
        chk("rst_mem_req", {63'd0, mrq}, 64'd0);
        chk("rst_resp_valid", {63'd0, rsv}, 64'd0);
        chk("rst_ready64", {63'd0, rr6}, 64'd1);
        rst = 1'b0;
        tick();
        // LB at 0x1003, ack after two BUS cycles
        req32(1'b0, 3'b000, 32'h1003, 32'h0);
        chk("lb_mem_req", {63'd0, mrq}, 64'd1);
        chk("lb_mem_addr", {32'd0, maddr}, 64'h1000);
        chk("lb_wstrb", {60'd0, mws}, 64'd0);
        chk("lb_we", {63'd0, mwe}, 64'd0);
        chk("lb_ready_bus", {63'd0, rr}, 64'd0);
        tick();
        chk("lb_still_bus", {63'd0, mrq}, 64'd1);
        ack = 1'b1; rd = 32'h80FF_FF00;
        tick();
        ack = 1'b0;
        chk("lb_resp_valid", {63'd0, rsv}, 64'd1);
        chk("lb_resp_data", {32'd0, rsd}, 64'hFFFF_FF80);
        chk("lb_fault", {63'd0, flt}, 64'd0);
        chk("lb_mem_req_resp", {63'd0, mrq}, 64'd0);
        tick();
        chk("lb_resp_pulse", {63'd0, rsv}, 64'd0);
        chk("lb_ready_after", {63'd0, rr}, 64'd1);
        // SH at 0x2002, immediate ack
        req32(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD);
        chk("sh_mem_addr", {32'd0, maddr}, 64'h2000);
        chk("sh_wstrb", {60'd0, mws}, 64'hC);
        chk("sh_wdata_hi", {48'd0, mwd[31:16]}, 64'hABCD);
        chk("sh_we", {63'd0, mwe}, 64'd1);
        ack = 1'b1; rd = 32'hFFFF_FFFF;
        tick();
        ack = 1'b0;
        chk("sh_resp_valid", {63'd0, rsv}, 64'd1);
        chk("sh_resp_data", {32'd0, rsd}, 64'd0);
        chk("sh_fault", {63'd0, flt}, 64'd0);
        tick();
        // SW at 0x40: full word lanes
        req32(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
        chk("sw_wstrb", {60'd0, mws}, 64'hF);
        chk("sw_wdata", {32'd0, mwd}, 64'hCAFE_F00D);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        // LHU at 0x10
        req32(1'b0, 3'b101, 32'h10, 32'h0);
        ack = 1'b1; rd = 32'h0000_8001;
        tick();
        ack = 1'b0;
        chk("lhu_data", {32'd0, rsd}, 64'h0000_8001);
        tick();
        // LH at 0x12: upper half sign-extended
        req32(1'b0, 3'b001, 32'h12, 32'h0);
        ack = 1'b1; rd = 32'h8001_0000;
        tick();
        ack = 1'b0;
        chk("lh_data", {32'd0, rsd}, 64'hFFFF_8001);
        tick();
        // LW at 0x14
        req32(1'b0, 3'b010, 32'h14, 32'h0);
        chk("lw_mem_addr", {32'd0, maddr}, 64'h14);
        ack = 1'b1; rd = 32'hDEAD_BEEF;
        tick();
        ack = 1'b0;
        chk("lw_data", {32'd0, rsd}, 64'hDEAD_BEEF);
        tick();
        // Misaligned LW at 0x1002
        req32(1'b0, 3'b010, 32'h1002, 32'h0);
        chk("mis_mem_req", {63'd0, mrq}, 64'd0);
        chk("mis_resp_valid", {63'd0, rsv}, 64'd1);
        chk("mis_fault", {63'd0, flt}, 64'd1);
        chk("mis_resp_data", {32'd0, rsd}, 64'd0);
        tick();
        chk("mis_fault_clear", {63'd0, flt}, 64'd0);
        // funct3 011 illegal at XLEN=32
        req32(1'b0, 3'b011, 32'h0, 32'h0);
        chk("ld32_mem_req", {63'd0, mrq}, 64'd0);
        chk("ld32_fault", {63'd0, flt}, 64'd1);
        tick();
        // Store with funct3 100 illegal
        req32(1'b1, 3'b100, 32'h8, 32'h55);
        chk("sbu_fault", {63'd0, flt}, 64'd1);
        chk("sbu_we", {63'd0, mwe}, 64'd0);
        tick();
        // mem_ack while idle is ignored
        ack = 1'b1; rd = 32'h1234_5678;
        tick();
        ack = 1'b0;
        chk("idle_ack_resp", {63'd0, rsv}, 64'd0);
        chk("idle_ack_ready", {63'd0, rr}, 64'd1);
        // Back-pressure: req_valid held, fields changed while busy
        rv = 1'b1; st = 1'b0; f3 = 3'b100; ad = 32'h5; sd = 0;
        tick();
        f3 = 3'b010; ad = 32'h20;
        chk("bp_ready_bus", {63'd0, rr}, 64'd0);
        chk("bp_mem_addr", {32'd0, maddr}, 64'h4);
        ack = 1'b1; rd = 32'h0000_AB00;
        tick();
        ack = 1'b0;
        chk("bp_lbu_data", {32'd0, rsd}, 64'hAB);
        chk("bp_ready_resp", {63'd0, rr}, 64'd0);
        tick();
        chk("bp_ready_idle", {63'd0, rr}, 64'd1);
        ad = 32'h24;
        tick();
        rv = 1'b0;
        chk("bp_second_addr", {32'd0, maddr}, 64'h24);
        ack = 1'b1; rd = 32'h1122_3344;
        tick();
        ack = 1'b0;
        chk("bp_second_data", {32'd0, rsd}, 64'h1122_3344);
        tick();
        // Reset asserted mid-BUS abandons the access
        req32(1'b0, 3'b010, 32'h30, 32'h0);
        chk("rb_mem_req", {63'd0, mrq}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rb_mem_req_drop", {63'd0, mrq}, 64'd0);
        chk("rb_ready", {63'd0, rr}, 64'd1);
        chk("rb_resp_valid", {63'd0, rsv}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rb_no_resp", {63'd0, rsv}, 64'd0);
        chk("rb_ready_after", {63'd0, rr}, 64'd1);
        // XLEN=64: LD at 0x8
        req64(1'b0, 3'b011, 64'h8, 64'h0);
        chk("ld64_mem_addr", maddr6, 64'h8);
        chk("ld64_wstrb", {56'd0, mws6}, 64'd0);
        ack6 = 1'b1; rd6 = 64'h8000_0000_0000_0001;
        tick();
        ack6 = 1'b0;
        chk("ld64_fault", {63'd0, flt6}, 64'd0);
        chk("ld64_data", rsd6, 64'h8000_0000_0000_0001);
        tick();
        // LWU at 0xC
        req64(1'b0, 3'b110, 64'hC, 64'h0);
        chk("lwu64_mem_addr", maddr6, 64'h8);
        chk("lwu64_wstrb", {56'd0, mws6}, 64'd0);
        ack6 = 1'b1; rd6 = 64'h8765_4321_0BAD_F00D;
        tick();
        ack6 = 1'b0;
        chk("lwu64_data", rsd6, 64'h0000_0000_8765_4321);
        tick();
        // LW at 0xC sign-extends the same word
        req64(1'b0, 3'b010, 64'hC, 64'h0);
        ack6 = 1'b1; rd6 = 64'h8765_4321_0BAD_F00D;
        tick();
        ack6 = 1'b0;
        chk("lw64_data", rsd6, 64'hFFFF_FFFF_8765_4321);
        tick();
        // SD at 0x10 and misaligned LD at 0x4
        req64(1'b1, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF);
        chk("sd64_wstrb", {56'd0, mws6}, 64'hFF);
        chk("sd64_wdata", mwd6, 64'h0123_4567_89AB_CDEF);
        ack6 = 1'b1;
        tick();
        ack6 = 1'b0;
        tick();
        req64(1'b0, 3'b011, 64'h4, 64'h0);
        chk("ld64_mis_fault", {63'd0, flt6}, 64'd1);
        chk("ld64_mis_req", {63'd0, mrq6}, 64'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
